// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//   Serial-to-bus loader. Decodes a big-endian byte command stream from the
//   UART receiver and masters the block-RAM bus with 16-bit word accesses.
//
//   Commands:
//     'W' (0x57) ADDR_H ADDR_L CNT_H CNT_L {DATA_H DATA_L} x CNT -> replies 'K'
//     'R' (0x52) ADDR_H ADDR_L CNT_H CNT_L -> replies CNT words, hi byte first
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_rx_dat, i_rx_valid     received byte + one-cycle strobe
//   o_tx_dat, o_tx_valid,
//   i_tx_ready               transmit byte, valid/ready handshake
//   o_dat, i_dat             bus write / read data
//   o_addr                   bus word address (AW bits, wraps)
//   o_we, o_cyc, o_stb       bus write enable, cycle, byte-lane strobes
//   i_ack                    bus acknowledge (may be combinational)
//   o_busy                   high whenever the loader is not idle
//   o_err                    one-cycle pulse on bad command or overrun
// -----------------------------------------------------------------------------
module mem_loader #(
  parameter int AW = 15
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [7:0]    i_rx_dat,
  input  logic          i_rx_valid,
  output logic [7:0]    o_tx_dat,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [15:0]   o_dat,
  input  logic [15:0]   i_dat,
  output logic [AW-1:0] o_addr,
  output logic          o_we,
  output logic          o_cyc,
  output logic [1:0]    o_stb,
  input  logic          i_ack,
  output logic          o_busy,
  output logic          o_err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR_H = 4'd1;
  localparam logic [3:0] S_ADDR_L = 4'd2;
  localparam logic [3:0] S_CNT_H  = 4'd3;
  localparam logic [3:0] S_CNT_L  = 4'd4;
  localparam logic [3:0] S_DATA_H = 4'd5;
  localparam logic [3:0] S_DATA_L = 4'd6;
  localparam logic [3:0] S_WR     = 4'd7;
  localparam logic [3:0] S_RD     = 4'd8;
  localparam logic [3:0] S_TX_H   = 4'd9;
  localparam logic [3:0] S_TX_L   = 4'd10;
  localparam logic [3:0] S_TX_ACK = 4'd11;

  localparam logic [7:0]    CMD_WR   = 8'h57;
  localparam logic [7:0]    CMD_RD   = 8'h52;
  localparam logic [7:0]    ACK_BYTE = 8'h4B;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [3:0]    state;
  logic          is_wr;
  logic [7:0]    hold_byte;   // ADDR_H until ADDR_L completes the address
  logic [AW-1:0] addr;
  logic [15:0]   cnt;
  logic [15:0]   wdat;
  logic [15:0]   rdat;
  logic          err;

  logic          busy_rx;     // states in which a received byte is an overrun
  logic          rx_err;
  logic [15:0]   cnt_word;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_rx  = 1'b0;
    rx_err   = 1'b0;
    cnt_word = {cnt[15:8], i_rx_dat};
    case (state)
      S_WR, S_RD, S_TX_H, S_TX_L, S_TX_ACK: busy_rx = 1'b1;
      default:                              busy_rx = 1'b0;
    endcase
    if (i_rx_valid) begin
      if (busy_rx) rx_err = 1'b1;
      else if (state == S_IDLE && i_rx_dat != CMD_WR && i_rx_dat != CMD_RD)
        rx_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: all registers, including the data holding registers, are reset so
    // the bus and transmit outputs are defined zeros straight out of reset.
    if (!i_reset_n) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      hold_byte <= 8'h00;
      addr      <= '0;
      cnt       <= 16'h0000;
      wdat      <= 16'h0000;
      rdat      <= 16'h0000;
      err       <= 1'b0;
    end else begin
      err <= rx_err;
      case (state)
        S_IDLE: if (i_rx_valid) begin
          if (i_rx_dat == CMD_WR) begin
            is_wr <= 1'b1;
            state <= S_ADDR_H;
          end else if (i_rx_dat == CMD_RD) begin
            is_wr <= 1'b0;
            state <= S_ADDR_H;
          end
        end
        S_ADDR_H: if (i_rx_valid) begin
          hold_byte <= i_rx_dat;
          state     <= S_ADDR_L;
        end
        S_ADDR_L: if (i_rx_valid) begin
          // 16-bit protocol address truncated to the RAM's word-address width.
          addr  <= AW'({hold_byte, i_rx_dat});
          state <= S_CNT_H;
        end
        S_CNT_H: if (i_rx_valid) begin
          cnt[15:8] <= i_rx_dat;
          state     <= S_CNT_L;
        end
        S_CNT_L: if (i_rx_valid) begin
          cnt[7:0] <= i_rx_dat;
          if (cnt_word == 16'h0000) state <= is_wr ? S_TX_ACK : S_IDLE;
          else                      state <= is_wr ? S_DATA_H : S_RD;
        end
        S_DATA_H: if (i_rx_valid) begin
          wdat[15:8] <= i_rx_dat;
          state      <= S_DATA_L;
        end
        S_DATA_L: if (i_rx_valid) begin
          wdat[7:0] <= i_rx_dat;
          state     <= S_WR;
        end
        S_WR: if (i_ack) begin
          addr  <= addr + ADDR_ONE;
          cnt   <= cnt - 16'd1;
          state <= (cnt == 16'd1) ? S_TX_ACK : S_DATA_H;
        end
        S_RD: if (i_ack) begin
          rdat  <= i_dat;
          state <= S_TX_H;
        end
        S_TX_H: if (i_tx_ready) state <= S_TX_L;
        S_TX_L: if (i_tx_ready) begin
          addr  <= addr + ADDR_ONE;
          cnt   <= cnt - 16'd1;
          state <= (cnt == 16'd1) ? S_IDLE : S_RD;
        end
        S_TX_ACK: if (i_tx_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus and transmit controls decode straight from the state so a reset
  // drops them in the same cycle.
  always_comb begin
    o_cyc      = (state == S_WR) || (state == S_RD);
    o_we       = (state == S_WR);
    o_stb      = o_cyc ? 2'b11 : 2'b00;
    o_tx_valid = (state == S_TX_H) || (state == S_TX_L) || (state == S_TX_ACK);
    o_busy     = (state != S_IDLE);
    o_tx_dat   = 8'h00;
    case (state)
      S_TX_H:   o_tx_dat = rdat[15:8];
      S_TX_L:   o_tx_dat = rdat[7:0];
      S_TX_ACK: o_tx_dat = ACK_BYTE;
      default:  o_tx_dat = 8'h00;
    endcase
  end

  assign o_addr = addr;
  assign o_dat  = wdat;
  assign o_err  = err;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
//   Directed bench for mem_loader with a RAM model (combinational or delayed
//   ack) and a scoreboard: stimulus pushes expected bus writes and transmit
//   bytes; a negedge monitor pops and compares as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_mem_loader;

  localparam int AW = 15;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [7:0]    i_rx_dat = 8'h00;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    o_tx_dat;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b1;
  logic [15:0]   o_dat;
  logic [15:0]   i_dat;
  logic [AW-1:0] o_addr;
  logic          o_we;
  logic          o_cyc;
  logic [1:0]    o_stb;
  logic          i_ack;
  logic          o_busy;
  logic          o_err;

  mem_loader #(.AW(AW)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_rx_dat   (i_rx_dat),
    .i_rx_valid (i_rx_valid),
    .o_tx_dat   (o_tx_dat),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_dat      (o_dat),
    .i_dat      (i_dat),
    .o_addr     (o_addr),
    .o_we       (o_we),
    .o_cyc      (o_cyc),
    .o_stb      (o_stb),
    .i_ack      (i_ack),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- RAM model ----------------
  logic [15:0]   ram [0:(1<<AW)-1];
  int            ack_delay = 0;
  int            wait_cnt = 0;
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [15:0]   pl_data = 16'h0000;

  assign i_ack = o_cyc && (wait_cnt == ack_delay);
  assign i_dat = ram[o_addr];

  always @(posedge i_clk) begin
    if (o_cyc && !i_ack) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
    if (pl_we)                      ram[pl_addr] <= pl_data;
    else if (o_cyc && o_we && i_ack) ram[o_addr] <= o_dat;
  end

  // ---------------- scoreboard / counters ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int n_vec = 0;
  int n_miss = 0;
  int bus_cnt = 0;
  int tx_cnt = 0;
  int err_cnt = 0;
  int run = 0;
  int exp_run = 0;   // expected bus-cycle length; 0 skips the length check
  bit tog = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
  endtask

  // Ready driver: always ready, or toggling every cycle when tog is set.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_tx_ready = tog ? ~i_tx_ready : 1'b1;
    end
  end

  // Monitor, sampling on the falling edge.
  logic          prev_cyc = 1'b0;
  logic [15:0]   prev_dat = 16'h0000;
  logic [AW-1:0] prev_addr = '0;
  logic          stalled = 1'b0;
  logic [7:0]    prev_txd = 8'h00;

  always @(negedge i_clk) begin
    if (o_err) err_cnt++;
    if (o_cyc) begin
      check("bus_stb", {30'd0, o_stb}, 32'd3);
      run++;
      if (prev_cyc) begin
        check("bus_dat_hold", {16'd0, o_dat}, {16'd0, prev_dat});
        check("bus_addr_hold", {17'd0, o_addr}, {17'd0, prev_addr});
      end
    end else if (run > 0) begin
      if (exp_run > 0) check("bus_len", run, exp_run);
      run = 0;
    end
    if (o_cyc && i_ack) begin
      bus_cnt++;
      if (o_we) begin
        if (exp_wr.size() == 0) fail("wr_unexpected");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", {17'd0, o_addr}, {17'd0, w.addr});
          check("wr_data", {16'd0, o_dat}, {16'd0, w.data});
        end
      end
    end
    if (stalled) begin
      check("tx_hold_valid", {31'd0, o_tx_valid}, 32'd1);
      check("tx_hold_dat", {24'd0, o_tx_dat}, {24'd0, prev_txd});
    end
    if (o_tx_valid && i_tx_ready) begin
      tx_cnt++;
      if (exp_tx.size() == 0) fail("tx_unexpected");
      else check("tx_byte", {24'd0, o_tx_dat}, {24'd0, exp_tx.pop_front()});
    end
    stalled   = o_tx_valid && !i_tx_ready;
    prev_txd  = o_tx_dat;
    prev_cyc  = o_cyc;
    prev_dat  = o_dat;
    prev_addr = o_addr;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while ((o_cyc || o_tx_valid) && n < 500) begin
      tick();
      n++;
    end
    if (o_cyc || o_tx_valid) begin
      $display("FAIL rx_wait_timeout: loader never became receptive (t=%0t)", $time);
      n_vec++;
      n_miss++;
    end
    i_rx_dat   = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 500) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_wr_drained"}, exp_wr.size(), 0);
    check({name, "_tx_drained"}, exp_tx.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int b0, t0, e0;

    // Power-on reset values.
    repeat (3) tick();
    check("rst_busy",  {31'd0, o_busy},     32'd0);
    check("rst_cyc",   {31'd0, o_cyc},      32'd0);
    check("rst_stb",   {30'd0, o_stb},      32'd0);
    check("rst_txv",   {31'd0, o_tx_valid}, 32'd0);
    check("rst_err",   {31'd0, o_err},      32'd0);
    check("rst_addr",  {17'd0, o_addr},     32'd0);
    check("rst_dat",   {16'd0, o_dat},      32'd0);
    i_reset_n = 1'b1;
    tick();

    // Reset asserted in the middle of a (slow-ack) write cycle.
    ack_delay = 3;
    exp_run   = 0;
    b0 = bus_cnt;
    send_seq('{8'h57, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22});
    check("abort_in_wr", {31'd0, o_cyc}, 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("abort_cyc",  {31'd0, o_cyc},      32'd0);
    check("abort_we",   {31'd0, o_we},       32'd0);
    check("abort_stb",  {30'd0, o_stb},      32'd0);
    check("abort_txv",  {31'd0, o_tx_valid}, 32'd0);
    check("abort_busy", {31'd0, o_busy},     32'd0);
    check("abort_err",  {31'd0, o_err},      32'd0);
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
    check("abort_idle",   {31'd0, o_busy}, 32'd0);
    check("abort_no_bus", bus_cnt - b0,    32'd0);

    // Two-word write with combinational ack.
    ack_delay = 0;
    exp_run   = 1;
    b0 = bus_cnt;
    exp_wr.push_back({15'h0010, 16'h1234});
    exp_wr.push_back({15'h0011, 16'hABCD});
    exp_tx.push_back(8'h4B);
    send_seq('{8'h57, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    wait_idle();
    check("wr_ram10", {16'd0, ram[15'h0010]}, 32'h1234);
    check("wr_ram11", {16'd0, ram[15'h0011]}, 32'hABCD);
    check("wr_buscnt", bus_cnt - b0, 32'd2);
    check_drained("wr");

    // Read across the address wrap with a stalling transmitter.
    preload(15'h7FFF, 16'hBEEF);
    preload(15'h0000, 16'h0102);
    b0 = bus_cnt;
    e0 = err_cnt;
    tog = 1'b1;
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h02);
    send_seq('{8'h52, 8'h7F, 8'hFF, 8'h00, 8'h02});
    wait_idle();
    tog = 1'b0;
    check("rd_buscnt", bus_cnt - b0, 32'd2);
    check("rd_no_err", err_cnt - e0, 32'd0);
    check_drained("rd");

    // Unknown command byte, then a zero-length write.
    b0 = bus_cnt;
    e0 = err_cnt;
    send_byte(8'h41);
    tick();
    tick();
    check("bad_err",    err_cnt - e0,      32'd1);
    check("bad_no_bus", bus_cnt - b0,      32'd0);
    check("bad_idle",   {31'd0, o_busy},   32'd0);
    exp_tx.push_back(8'h4B);
    send_seq('{8'h57, 8'h00, 8'h00, 8'h00, 8'h00});
    wait_idle();
    check("w0_no_bus", bus_cnt - b0, 32'd0);
    check_drained("w0");

    // Delayed ack (3 cycles late) with a byte injected during WR.
    ack_delay = 3;
    exp_run   = 4;
    b0 = bus_cnt;
    e0 = err_cnt;
    exp_wr.push_back({15'h0030, 16'hCAFE});
    exp_tx.push_back(8'h4B);
    send_seq('{8'h57, 8'h00, 8'h30, 8'h00, 8'h01, 8'hCA, 8'hFE});
    tick();
    i_rx_dat   = 8'h99;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    wait_idle();
    check("dly_ram30",  {16'd0, ram[15'h0030]}, 32'hCAFE);
    check("dly_err",    err_cnt - e0,           32'd1);
    check("dly_buscnt", bus_cnt - b0,           32'd1);
    check_drained("dly");

    // Zero-length read: no bus cycle, no transmit, straight back to idle.
    ack_delay = 0;
    exp_run   = 1;
    b0 = bus_cnt;
    t0 = tx_cnt;
    send_seq('{8'h52, 8'h00, 8'h05, 8'h00, 8'h00});
    check("r0_idle", {31'd0, o_busy}, 32'd0);
    repeat (3) tick();
    check("r0_no_bus", bus_cnt - b0, 32'd0);
    check("r0_no_tx",  tx_cnt - t0,  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Serial-to-bus loader that sits directly upstream of the block RAM and masters its bus.
- Consumes a byte stream from the UART receiver and decodes write and read-back commands.
- Drives 16-bit word accesses onto the memory bus; read-back data returns to the UART transmitter as bytes.
- Used to download program images into RAM and verify them before the CPU is released.

Parameters:
AW, 15, memory word-address width; must match the RAM's AW.

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_rx_dat  input  8  received byte
i_rx_valid  input  1  one-cycle strobe, i_rx_dat valid
o_tx_dat  output  8  byte to transmit
o_tx_valid  output  1  transmit request, held until accepted
i_tx_ready  input  1  transmitter accepts o_tx_dat when high with o_tx_valid
o_dat  output  16  bus write data
i_dat  input  16  bus read data
o_addr  output  AW  bus word address
o_we  output  1  bus write enable
o_cyc  output  1  bus cycle
o_stb  output  2  byte lane strobes, always 2'b11 during a cycle
i_ack  input  1  bus acknowledge; may be combinational, same cycle as o_cyc
o_busy  output  1  high in every state except IDLE
o_err  output  1  one-cycle pulse on protocol error or overrun

Behaviour:
- Reset (async, i_reset_n low):
  - State IDLE.
  - All outputs 0, including o_stb = 2'b00.
  - Address, count and data registers cleared.
  - A reset mid-command aborts it; a bus cycle in flight is dropped at once.
- Protocol, bytes big-endian:
  - Write: 0x57 ('W'), ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words, each sent as hi byte then lo byte.
  - Read: 0x52 ('R'), ADDR_H, ADDR_L, CNT_H, CNT_L.
  - The 16-bit address is truncated to its low AW bits.
- States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, WR, RD, TX_H, TX_L, TX_ACK.
- IDLE, on i_rx_valid:
  - 0x57 or 0x52: latch the command and go to ADDR_H.
  - Any other byte: pulse o_err, stay in IDLE.
- Header states: ADDR_H -> ADDR_L -> CNT_H -> CNT_L, each advancing on one i_rx_valid.
- After CNT_L:
  - CNT == 0: write goes to TX_ACK; read returns to IDLE.
  - Otherwise: write goes to DATA_H, read goes to RD.
- Write path:
  - DATA_H latches o_dat[15:8]; DATA_L latches o_dat[7:0], then goes to WR.
  - WR: o_cyc=1, o_we=1, o_stb=2'b11, stable until the rising edge where i_ack=1.
  - That edge drops o_cyc, o_we and o_stb, increments the address, decrements the count.
  - Next state: DATA_H if count remains, else TX_ACK.
  - With combinational ack, WR lasts exactly one cycle.
- Read path:
  - RD: o_cyc=1, o_we=0, o_stb=2'b11.
  - The edge with i_ack=1 captures i_dat, drops the cycle and goes to TX_H.
  - TX_H presents the hi byte, TX_L the lo byte; o_tx_valid stays high until i_tx_ready.
  - After TX_L is accepted: address+1, count-1, then RD if count remains, else IDLE.
- TX_ACK: sends 0x4B ('K') with the same valid/ready handshake, then returns to IDLE.
- Address increments wrap modulo 2**AW (all-ones -> 0). The count is a 16-bit down-counter.
- Overrun: i_rx_valid while in WR, RD, TX_H, TX_L or TX_ACK.
  - The byte is discarded and o_err pulses.
  - State and data are unaffected.
  - If i_ack arrives in the same cycle, the bus access still completes normally.
- o_tx_valid never drops before it is accepted. o_tx_dat is stable while o_tx_valid is high.
- o_busy is combinational from the state: high whenever state != IDLE.

Test Plan:
- Reset with i_reset_n low mid-WR -> o_cyc, o_we, o_stb, o_tx_valid, o_busy, o_err all 0 within the same cycle; state IDLE after release.
- Send 57 00 10 00 02 12 34 AB CD with the combinational-ack RAM model:
  - RAM[0x10]=0x1234 and RAM[0x11]=0xABCD.
  - Each WR lasts 1 cycle with o_stb=11.
  - Then one 0x4B byte on tx.
- Preload RAM[0x7FFF]=0xBEEF, RAM[0]=0x0102, send 52 7F FF 00 02, with i_tx_ready toggling every other cycle:
  - tx sequence BE EF 01 02 (address wraps from 0x7FFF to 0).
  - o_tx_dat stable while stalled.
- Send 0x41 -> one o_err pulse, no bus cycle. Then send 57 00 00 00 00 -> immediate 0x4B, no bus cycle.
- Delayed-ack bus model with i_ack 3 cycles late, plus a byte injected during WR:
  - o_cyc and o_dat held for 4 cycles.
  - The injected byte is dropped with an o_err pulse; the written word is unaffected.
- Send 52 00 05 00 00 -> no bus cycle, no tx, return to IDLE (o_busy low).
